zm_env_follow: RTL and testbench
================================

# zm_env_follow

Envelope follower and onset-gate detector for the audio path. It works in the opposite direction to the triggered decay generator: it takes a stream of signed I2S samples and rectifies them. It tracks a peak envelope with instant attack and a linear, programmable release. When the envelope crosses a threshold it raises a gate and emits a one-cycle trigger, so incoming audio can re-trigger the synth's envelope and voice blocks.

## Interface
- `HOLD_CYCLES`, default 4800: minimum gate-high duration in clk cycles after each onset.
- `clk` in 1: system clock; the block runs in a single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `sample_in` in 16: signed two's-complement audio sample.
- `sample_valid` in 1: one-cycle strobe; `sample_in` is sampled on the clk edge where it is high.
- `release_time` in 16: release rate; only bits [15:4] are used.
- `threshold` in 15: onset level, unsigned. A value of 0 disables the gate.
- `hysteresis` in 15: drop-out margin below `threshold`.
- `envelope` out 16: current envelope, unsigned; bit 15 is always 0.
- `gate` out 1: high while the FSM is in HOLD or ON.
- `trig_pulse` out 1: one-cycle pulse on each onset.

## Operation
- **Stage 1 (rectify):** on `sample_valid`, `mag <= |sample_in|`.
  - 0x8000 saturates to 0x7FFF.
  - `mag` is a 15-bit register, and a flag `mag_v` is registered alongside it.
- **Release tick counter:**
  - 12-bit down-counter, free-running.
  - When the count is 0, the counter reloads `release_time[15:4]` and asserts `tick` for that cycle; otherwise it decrements.
  - Result: `tick` asserts every `release_time[15:4]+1` cycles. A value of 0 means every cycle.
- **Stage 2 (envelope), evaluated on each edge in priority order:**
  1. If `mag_v` and `mag > env`: `env <= mag` (attack wins over a simultaneous tick).
  2. Otherwise, if `tick` and `env > 0`: `env <= env - 1`.
  3. Otherwise `env` holds. It never wraps below 0.
- **Lower threshold:** `lo = threshold - hysteresis`, saturating at 0, 15-bit unsigned.
- **Gate FSM (IDLE, HOLD, ON), evaluated on the registered `env`:**
  - IDLE → HOLD when `threshold != 0` and `env >= threshold`. On this transition `trig_pulse` is high for exactly the following cycle, and the hold counter loads `HOLD_CYCLES-1`.
  - HOLD: the hold counter decrements every cycle. When it reaches 0 the FSM moves to ON. New crossings in HOLD are ignored (no retrigger).
  - ON → IDLE when `env < lo`, or when `threshold == 0`.
  - ON → ON otherwise. There is no retrigger from ON; a new onset requires a return to IDLE.
  - `gate` is 1 in HOLD and ON.
- **Threshold changes:**
  - `threshold`/`hysteresis` may change at any time and take effect on the next comparison.
  - Setting `threshold=0` while in HOLD does not end the hold early. It forces IDLE once ON is reached.

## Timing
- **Reset values:** `envelope=0`, `gate=0`, `trig_pulse=0`, FSM=IDLE, `mag=0`, `mag_v=0`, tick counter=0, hold counter=0.
- Reset is asynchronous: all outputs go to 0 immediately on `rst` rising, including mid-HOLD or mid-ON, and no pulse is emitted on exit.
- **Latency, with `sample_valid` sampled at edge t:**
  - `mag` is valid after t.
  - `envelope` is updated after edge t+1.
  - FSM transition happens at edge t+2, so `gate` and `trig_pulse` are high in the cycle after edge t+2.
- `trig_pulse` is high for exactly one cycle per IDLE→HOLD transition.
- Back-to-back `sample_valid` on every cycle is supported at full rate; there is no backpressure.
- The first `tick` after reset occurs at the first edge after `rst` deasserts, because the counter resets to 0.

## Test plan
1. **Reset:** assert `rst` with random inputs → `envelope=0`, `gate=0`, `trig_pulse=0`. Deassert, hold `sample_valid=0` → outputs stay 0.
2. **Onset:** `threshold=0x2000`, `hysteresis=0x0800`, `release_time=0xFFF0`, one `sample_valid` with 0x4000 at edge t → `envelope=0x4000` after edge t+1; `trig_pulse` high for one cycle after edge t+2, simultaneous with `gate` rising.
3. **Release and drop-out:** as case 2 but `release_time=0x0010` and `HOLD_CYCLES=4`, no further samples → `envelope` decrements by 1 every 2 cycles. `gate` stays high through HOLD and falls the cycle after `envelope` reaches 0x17FF. No second `trig_pulse`. `envelope` stops at 0.
4. **Rectify saturation and attack priority:**
   - Sample 0x8000 → `envelope=0x7FFF`.
   - Sample 0xC000 (-0x4000) while env=0x3000 → `envelope=0x4000`.
   - Sample 0x1000 while env=0x3000 on a tick cycle → `envelope=0x2FFF`.
5. **Hold and no-retrigger:** `HOLD_CYCLES=100`, onset, then repeated crossings and dips below `lo` within 100 cycles → `gate` stays 1, exactly one `trig_pulse`. After HOLD, a dip below `lo` then a re-cross → second `trig_pulse`.
6. **Reset mid-ON and threshold=0:**
   - Assert `rst` while `gate=1` → `gate`, `envelope` and `trig_pulse` go to 0 asynchronously.
   - With `threshold=0` and a sample of 0x7FFF → `gate` never rises.

Source files
------------

// File: rtl/zm_env_follow.sv
// rtl/zm_env_follow.sv - peak envelope follower with onset gate and trigger
// Rectify -> envelope (instant attack, linear release) -> IDLE/HOLD/ON gate FSM.
module zm_env_follow #(
  parameter int HOLD_CYCLES = 4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [15:0] release_time,
  input  logic [14:0] threshold,
  input  logic [14:0] hysteresis,
  output logic [15:0] envelope,
  output logic        gate,
  output logic        trig_pulse
);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t        state;
  logic [14:0]   mag;
  logic          mag_v;
  logic [14:0]   env;
  logic [11:0]   tick_cnt;
  logic          tick;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   neg_sample;
  logic [14:0]   abs_sample;
  logic [14:0]   lo;
  logic          unused_release_lsbs;

  assign unused_release_lsbs = ^release_time[3:0];

  // -32768 has no positive 16-bit counterpart, so it clamps to full scale
  assign neg_sample = -sample_in;
  always_comb begin
    abs_sample = sample_in[14:0];
    if (sample_in[15]) begin
      abs_sample = (sample_in == 16'h8000) ? 15'h7FFF : neg_sample[14:0];
    end
  end

  assign lo       = (threshold > hysteresis) ? (threshold - hysteresis) : 15'd0;
  assign tick     = (tick_cnt == 12'd0);
  assign envelope = {1'b0, env};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag   <= '0;
      mag_v <= 1'b0;
    end else begin
      mag_v <= sample_valid;
      if (sample_valid) begin
        mag <= abs_sample;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= release_time[15:4];
    end else begin
      tick_cnt <= tick_cnt - 12'd1;
    end
  end

  // Attack takes priority over a release tick landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env <= '0;
    end else if (mag_v && (mag > env)) begin
      env <= mag;
    end else if (tick && (env != 15'd0)) begin
      env <= env - 15'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      gate       <= 1'b0;
      trig_pulse <= 1'b0;
    end else begin
      trig_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((threshold != 15'd0) && (env >= threshold)) begin
            state      <= S_HOLD;
            hold_cnt   <= HOLD_LOAD;
            gate       <= 1'b1;
            trig_pulse <= 1'b1;
          end
        end
        // Crossings and dips are ignored until the hold expires
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state <= S_ON;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        S_ON: begin
          if ((threshold == 15'd0) || (env < lo)) begin
            state <= S_IDLE;
            gate  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          gate  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zm_env_follow.sv
// tb/tb_zm_env_follow.sv - directed self-checking bench for zm_env_follow
// E<n> is the n-th rising edge after reset release; values are checked 1 ns after each edge.
module tb_zm_env_follow;

  localparam int HOLD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] release_time;
  logic [14:0] threshold;
  logic [14:0] hysteresis;
  logic [15:0] envelope;
  logic        gate;
  logic        trig_pulse;

  int total = 0;
  int bad   = 0;

  int trig_cnt, trig_first, trig_second, n_17ff, n_gate_lo, n_zero, gate_lo_cnt, gate_hi_cnt;
  logic [15:0] env_a, env_b;
  logic g34, g35, g61, g62;

  zm_env_follow #(.HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .release_time (release_time),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .envelope     (envelope),
    .gate         (gate),
    .trig_pulse   (trig_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    release_time = 16'hFFF0;
    threshold = 15'h2000;
    hysteresis = 15'h0800;

    // reset with random inputs
    repeat (6) begin
      sample_in = 16'($urandom);
      sample_valid = 1'($urandom);
      threshold = 15'($urandom);
      hysteresis = 15'($urandom);
      release_time = 16'($urandom);
      step();
    end
    check("rst_env", envelope, 0);
    check("rst_gate", gate, 0);
    check("rst_trig", trig_pulse, 0);
    sample_valid = 1'b0;
    rst = 1'b0;
    gate_hi_cnt = 0;
    trig_cnt = 0;
    n_zero = 0;
    repeat (5) begin
      step();
      if (gate) gate_hi_cnt++;
      if (trig_pulse) trig_cnt++;
      if (envelope != 16'h0) n_zero++;
    end
    check("idle_gate_cnt", gate_hi_cnt, 0);
    check("idle_trig_cnt", trig_cnt, 0);
    check("idle_env_nonzero_cnt", n_zero, 0);

    // onset latency
    threshold = 15'h2000; hysteresis = 15'h0800; release_time = 16'hFFF0;
    do_reset();
    sample_in = 16'h4000; sample_valid = 1'b1;
    step(); sample_valid = 1'b0;
    check("onset_env_e0", envelope, 16'h0000);
    step();
    check("onset_env_e1", envelope, 16'h4000);
    check("onset_gate_e1", gate, 0);
    check("onset_trig_e1", trig_pulse, 0);
    step();
    check("onset_gate_e2", gate, 1);
    check("onset_trig_e2", trig_pulse, 1);
    step();
    check("onset_gate_e3", gate, 1);
    check("onset_trig_e3", trig_pulse, 0);

    // release every 2 cycles and drop-out at lo = 0x1800
    release_time = 16'h0010;
    do_reset();
    trig_cnt = 0; trig_first = -1; n_17ff = -1; n_gate_lo = -1; n_zero = -1;
    env_a = '0; env_b = '0;
    sample_in = 16'h4000;
    for (int n = 0; n <= 32'h8008; n++) begin
      sample_valid = (n == 0);
      step();
      if (trig_pulse) begin
        trig_cnt++;
        if (trig_first < 0) trig_first = n;
      end
      if (envelope == 16'h17FF && n_17ff < 0) n_17ff = n;
      if (!gate && n > 2 && n_gate_lo < 0) n_gate_lo = n;
      if (envelope == 16'h0 && n > 1 && n_zero < 0) n_zero = n;
      if (n == 256) env_a = envelope;
      if (n == 257) env_b = envelope;
    end
    check("rel_trig_cnt", trig_cnt, 1);
    check("rel_trig_edge", trig_first, 2);
    check("rel_env_e256", env_a, 16'h3F80);
    check("rel_env_e257", env_b, 16'h3F80);
    check("rel_env17ff_edge", n_17ff, 32'h5002);
    check("rel_gate_fall_edge", n_gate_lo, 32'h5003);
    check("rel_env_zero_edge", n_zero, 32'h8000);
    check("rel_env_floor", envelope, 16'h0000);
    check("rel_gate_end", gate, 0);

    // saturation of -32768
    release_time = 16'hFFF0;
    do_reset();
    sample_in = 16'h8000; sample_valid = 1'b1;
    step(); sample_valid = 1'b0;
    step();
    check("sat_env", envelope, 16'h7FFF);

    // negative sample attacks above current envelope
    do_reset();
    sample_in = 16'h3000; sample_valid = 1'b1;
    step();
    sample_in = 16'hC000;
    step(); sample_valid = 1'b0;
    check("neg_env_e1", envelope, 16'h3000);
    step();
    check("neg_env_e2", envelope, 16'h4000);

    // smaller sample on a tick edge still releases
    release_time = 16'h0000;
    do_reset();
    sample_in = 16'h3000; sample_valid = 1'b1;
    step();
    sample_in = 16'h1000;
    step(); sample_valid = 1'b0;
    check("tick_env_e1", envelope, 16'h3000);
    step();
    check("tick_env_e2", envelope, 16'h2FFF);
    step();
    check("tick_env_e3", envelope, 16'h2FFE);

    // hold ignores dips and re-crossings; retrigger only from IDLE
    threshold = 15'h0010; hysteresis = 15'h0008; release_time = 16'h0000;
    do_reset();
    trig_cnt = 0; trig_first = -1; trig_second = -1; n_gate_lo = -1; gate_lo_cnt = 0;
    g61 = 1'b1; g62 = 1'b0;
    sample_in = 16'h0020;
    for (int n = 0; n <= 70; n++) begin
      sample_valid = (n == 0 || n == 29 || n == 60);
      step();
      if (trig_pulse) begin
        trig_cnt++;
        if (trig_first < 0) trig_first = n;
        else if (trig_second < 0) trig_second = n;
      end
      if (n >= 2 && n <= 55 && !gate) gate_lo_cnt++;
      if (!gate && n > 2 && n_gate_lo < 0) n_gate_lo = n;
      if (n == 61) g61 = gate;
      if (n == 62) g62 = gate;
    end
    check("hold_trig_cnt", trig_cnt, 2);
    check("hold_trig_first", trig_first, 2);
    check("hold_trig_second", trig_second, 62);
    check("hold_gate_low_cnt", gate_lo_cnt, 0);
    check("hold_gate_fall_edge", n_gate_lo, 56);
    check("hold_gate_e61", g61, 0);
    check("hold_gate_e62", g62, 1);

    // threshold cleared during HOLD forces IDLE right after ON is reached
    threshold = 15'h2000; hysteresis = 15'h0800; release_time = 16'hFFF0;
    do_reset();
    trig_cnt = 0; g34 = 1'b0; g35 = 1'b1;
    sample_in = 16'h4000;
    for (int n = 0; n <= 40; n++) begin
      sample_valid = (n == 0);
      if (n >= 10) threshold = 15'h0000;
      step();
      if (trig_pulse) trig_cnt++;
      if (n == 34) g34 = gate;
      if (n == 35) g35 = gate;
    end
    check("thr0_trig_cnt", trig_cnt, 1);
    check("thr0_gate_e34", g34, 1);
    check("thr0_gate_e35", g35, 0);

    // async reset while a trigger pulse is high
    threshold = 15'h2000;
    do_reset();
    sample_in = 16'h4000; sample_valid = 1'b1;
    step(); sample_valid = 1'b0;
    step(); step();
    check("arst_trig_pre", trig_pulse, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_trig", trig_pulse, 0);
    check("arst_trig_gate", gate, 0);
    @(posedge clk); #1 rst = 1'b0;

    // async reset mid-ON, no pulse on exit
    do_reset();
    sample_in = 16'h4000;
    for (int n = 0; n < 40; n++) begin
      sample_valid = (n == 0);
      step();
    end
    check("on_gate_pre", gate, 1);
    check("on_env_pre", envelope, 16'h4000);
    #2 rst = 1'b1;
    #1;
    check("on_arst_gate", gate, 0);
    check("on_arst_env", envelope, 16'h0000);
    check("on_arst_trig", trig_pulse, 0);
    @(posedge clk); #1 rst = 1'b0;
    trig_cnt = 0;
    repeat (4) begin
      step();
      if (trig_pulse) trig_cnt++;
    end
    check("on_arst_exit_trig", trig_cnt, 0);

    // threshold of 0 disables the gate
    threshold = 15'h0000;
    do_reset();
    gate_hi_cnt = 0; trig_cnt = 0;
    sample_in = 16'h7FFF;
    for (int n = 0; n < 40; n++) begin
      sample_valid = (n == 0);
      step();
      if (n == 1) env_a = envelope;
      if (gate) gate_hi_cnt++;
      if (trig_pulse) trig_cnt++;
    end
    check("thr0_env", env_a, 16'h7FFF);
    check("thr0_gate_cnt", gate_hi_cnt, 0);
    check("thr0_trig_none", trig_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
